// File: rtl/ycbcr_to_rgb_seq.sv
// YCbCr (level-shifted, signed 8-bit) to 8-bit RGB converter using a bit-serial shift-add multiplier.
// Latency: 9 cycles from accept to out_valid (8 MUL + 1 FINAL); one pixel in flight, II = 11.
// Backpressure: result held in OUT until out_ready; in_ready is high only in IDLE (registered).
module ycbcr_to_rgb_seq (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] y,
  input  logic signed [7:0] cb,
  input  logic signed [7:0] cr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b
);

  localparam logic [24:0] K_RCR = 25'h00166E9;
  localparam logic [24:0] K_GCB = 25'h000581A;
  localparam logic [24:0] K_GCR = 25'h000B6D2;
  localparam logic [24:0] K_BCB = 25'h001C5A2;

  typedef enum logic [1:0] {IDLE, MUL, FINAL, OUT} state_t;

  state_t             state, state_nxt;
  logic [2:0]         cnt;
  logic [7:0]         luma;
  logic               cb_neg, cr_neg;
  logic [7:0]         cb_mag, cr_mag;
  logic [24:0]        acc_rcr, acc_gcr, acc_gcb, acc_bcb;
  logic signed [26:0] base, v_r, v_g, v_b;

  function automatic logic [7:0] mag8(input logic [7:0] v);
    return v[7] ? 8'(8'd0 - v) : v;
  endfunction

  function automatic logic signed [26:0] apply_sign(input logic [24:0] a, input logic neg);
    logic signed [26:0] s;
    s = signed'({2'b00, a});
    return neg ? -s : s;
  endfunction

  // Round half-up at bit 16, then saturate to the unsigned 8-bit range.
  function automatic logic [7:0] round_clamp(input logic signed [26:0] v);
    logic signed [26:0] t;
    t = (v + 27'sd32768) >>> 16;
    if (t < 27'sd0)
      return 8'd0;
    else if (t > 27'sd255)
      return 8'd255;
    else
      return t[7:0];
  endfunction

  always_comb begin
    base = signed'({3'b000, luma, 16'h0000});
    v_r  = base + apply_sign(acc_rcr, cr_neg);
    v_g  = base - apply_sign(acc_gcb, cb_neg) - apply_sign(acc_gcr, cr_neg);
    v_b  = base + apply_sign(acc_bcb, cb_neg);
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = MUL;
      end
      MUL: begin
        if (cnt == 3'd7)
          state_nxt = FINAL;
      end
      FINAL: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 3'd0;
      luma    <= 8'd0;
      cb_neg  <= 1'b0;
      cr_neg  <= 1'b0;
      cb_mag  <= 8'd0;
      cr_mag  <= 8'd0;
      acc_rcr <= 25'd0;
      acc_gcr <= 25'd0;
      acc_gcb <= 25'd0;
      acc_bcb <= 25'd0;
      r       <= 8'd0;
      g       <= 8'd0;
      b       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Flipping the sign bit turns y-128 back into the unsigned luma.
            luma    <= {~y[7], y[6:0]};
            cb_neg  <= cb[7];
            cr_neg  <= cr[7];
            cb_mag  <= mag8(cb);
            cr_mag  <= mag8(cr);
            cnt     <= 3'd0;
            acc_rcr <= 25'd0;
            acc_gcr <= 25'd0;
            acc_gcb <= 25'd0;
            acc_bcb <= 25'd0;
          end
        end
        MUL: begin
          if (cr_mag[cnt]) begin
            acc_rcr <= acc_rcr + (K_RCR << cnt);
            acc_gcr <= acc_gcr + (K_GCR << cnt);
          end
          if (cb_mag[cnt]) begin
            acc_gcb <= acc_gcb + (K_GCB << cnt);
            acc_bcb <= acc_bcb + (K_BCB << cnt);
          end
          cnt <= cnt + 3'd1;
        end
        FINAL: begin
          r <= round_clamp(v_r);
          g <= round_clamp(v_g);
          b <= round_clamp(v_b);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ycbcr_to_rgb_seq.md
# ycbcr_to_rgb_seq

Sequential YCbCr-to-RGB colour converter for the decode path, the inverse of the encoder's RGB-to-YCbCr stage. It accepts one level-shifted pixel (Y−128, Cb, Cr as signed 8-bit values, which is the form the encoder produces and the decoder's inverse transform returns). It computes the inverse transform with a bit-serial shift-add multiplier over 8 cycles, then rounds and clamps to 8-bit unsigned RGB. Input and output use valid/ready handshakes.

## Interface
- No parameters; all coefficients are fixed constants (Q2.16 unsigned):
  - K_RCR = 0x166E9 (1.402)
  - K_GCB = 0x0581A (0.344136)
  - K_GCR = 0x0B6D2 (0.714136)
  - K_BCB = 0x1C5A2 (1.772)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel present
- in_ready  out  1  block can accept a pixel
- y  in  8  signed, level-shifted luma (Y−128)
- cb  in  8  signed chroma Cb
- cr  in  8  signed chroma Cr
- out_valid  out  1  r/g/b hold a result
- out_ready  in  1  downstream accepts result
- r, g, b  out  8 each  unsigned colour components

## Operation
- Transform:
  - R = Y + 1.402·Cr
  - G = Y − 0.344136·Cb − 0.714136·Cr
  - B = Y + 1.772·Cb
  - Y here is y + 128.
- FSM states:
  - IDLE: in_ready = 1. When in_valid = 1, capture y, sign(cb), |cb|, sign(cr), |cr|, clear the four product accumulators and bit counter, and go to MUL.
  - MUL: 8 cycles, counter i = 0..7.
    - If |cr|[i] = 1: acc_rcr += K_RCR << i and acc_gcr += K_GCR << i.
    - If |cb|[i] = 1: acc_gcb += K_GCB << i and acc_bcb += K_BCB << i.
    - At i = 7, go to FINAL.
  - FINAL: one cycle. Apply signs and form:
    - vR = (y+128)<<16 ± acc_rcr
    - vG = (y+128)<<16 ∓ acc_gcb ∓ acc_gcr
    - vB = (y+128)<<16 ± acc_bcb
    - Round: v' = (v + 0x8000) >>> 16, arithmetic.
    - Clamp: v' < 0 → 0; v' > 255 → 255.
    - Register the results into r/g/b and go to OUT.
  - OUT: out_valid = 1, and r/g/b are held stable. When out_ready = 1, go to IDLE.
- Widths:
  - Magnitudes are 8-bit unsigned; −128 gives magnitude 0x80.
  - Accumulators are unsigned, at least 25 bits; the maximum is 128·0x1C5A2 < 2^24.
  - The signed combination is 27 bits; it must not overflow for any input.
- in_ready is 0 in MUL, FINAL and OUT, so in_valid is ignored outside IDLE. There is no input buffering.
- out_ready is ignored outside OUT.
- rst takes priority over every transition and may arrive in any state. On reset:
  - state goes to IDLE and the counter and accumulators are cleared;
  - in_ready = 1, out_valid = 0, r = g = b = 0 from the next cycle;
  - any in-flight pixel is dropped and never emitted.

## Timing
- Reset values: in_ready = 1, out_valid = 0, r = 0, g = 0, b = 0.
- Accept occurs at edge E0, when in_valid & in_ready.
- MUL occupies edges E1..E8 and FINAL occurs at E9.
- out_valid = 1 and r/g/b are valid from the cycle after E9: latency is 9 cycles from accept.
- If out_ready = 1 in the first OUT cycle:
  - the output handshake completes at E10;
  - in_ready = 1 after E10;
  - the next accept can occur at E11, so the minimum initiation interval is 11 cycles.
- While out_ready = 0, the block stays in OUT indefinitely and r/g/b and out_valid are unchanged.
- in_ready = 1 exactly when the state is IDLE (registered state, no combinational path from out_ready).

## Test plan
- Neutral and extremes, no clamping from chroma (cb = 0, cr = 0):
  - y = 0 → (128, 128, 128)
  - y = 127 → (255, 255, 255)
  - y = −128 → (0, 0, 0)
- Typical pixel: y = −28 (Y = 100), cb = 10, cr = −20 → (72, 111, 118).
- Clamping:
  - y = 0, cb = 0, cr = 127 → (255, 37, 128)
  - y = 0, cb = −128, cr = 0 → (128, 172, 0)
- Handshake and latency:
  - Hold in_valid = 1 with out_ready = 1 throughout. Check out_valid rises exactly 9 cycles after each accept.
  - Check in_ready is 0 from E1 until the output handshake, and accepts occur every 11 cycles.
- Back-pressure:
  - Hold out_ready = 0 for 20 cycles after out_valid rises. r/g/b must stay constant and in_ready must stay 0.
  - A pulse on in_valid during the stall is not accepted.
  - Releasing out_ready completes exactly one transfer.
- Reset mid-operation:
  - Assert rst during MUL cycle i = 4, then present a new pixel (y = 0, cb = 0, cr = 0).
  - Only (128, 128, 128) is emitted, 9 cycles after its accept.
  - r/g/b read 0 and out_valid reads 0 immediately after the reset.
- Randomized sweep: 1000 random (y, cb, cr) with random out_ready stalls. Compare against a reference model using the exact Q2.16 constants and rounding rule above; all results must match exactly.
